// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache:
// FSM state enum, address-split width helpers and the tree-PLRU function pair.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    REFILL
  } state_e;

  // Tree storage for up to 4 ways: bit0 = root, bit1 = ways 0/1, bit2 = ways 2/3.
  localparam int PLRU_W = 3;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int line_words);
    return 32 - idx_bits(sets) - off_bits(line_words);
  endfunction

  // Follow the tree toward the least-recently-used leaf (0 = left, 1 = right).
  function automatic logic [1:0] plru_victim(input logic [PLRU_W-1:0] bits, input int ways);
    logic [1:0] way;
    way = 2'd0;
    if (ways == 4) begin
      way = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end else if (ways == 2) begin
      way = {1'b0, bits[0]};
    end
    return way;
  endfunction

  // Point every node on the accessed path away from the accessed way.
  function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] bits,
                                                    input logic [1:0] way, input int ways);
    logic [PLRU_W-1:0] nb;
    nb = bits;
    if (ways == 4) begin
      nb[0] = ~way[1];
      if (way[1]) nb[2] = ~way[0];
      else        nb[1] = ~way[0];
    end else if (ways == 2) begin
      nb[0] = ~way[0];
    end
    return nb;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU storage; reports the victim way of the indexed set
// and marks a way most-recently-used when update is enabled.
module icache_plru
  import icache_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic [$clog2(SETS)-1:0]  index_i,
  input  logic                     upd_en_i,
  input  logic [1:0]               upd_way_i,
  output logic [1:0]               victim_o
);

  logic [PLRU_W-1:0] plru_q [SETS];

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (upd_en_i) begin
      plru_q[index_i] <= plru_update(plru_q[index_i], upd_way_i, WAYS);
    end
  end

  assign victim_o = plru_victim(plru_q[index_i], WAYS);

endmodule

// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with tree-PLRU replacement.
// Define ICACHE_FLUSH_EN to add the flush port and whole-cache invalidate.
module icache_sa
  import icache_pkg::*;
#(
  parameter int SETS       = 8,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [31:0]                       address,
  output logic [31:0]                       instruction,
  output logic                              busywait,
  output logic                              mem_read,
  output logic [31-off_bits(LINE_WORDS):0]  mem_address,
  input  logic [32*LINE_WORDS-1:0]          mem_readdata,
  input  logic                              mem_busywait
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                              flush
`endif
);

  localparam int OFF_BITS = off_bits(LINE_WORDS);
  localparam int IDX_BITS = idx_bits(SETS);
  localparam int TAG_BITS = tag_bits(SETS, LINE_WORDS);
  localparam int LA_BITS  = 32 - OFF_BITS;
  localparam int WSEL_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  state_e                    state_q, state_d;
  logic [LA_BITS-1:0]        miss_line_q, miss_line_d;
  logic [1:0]                victim_q, victim_d;

  logic [WAYS-1:0]           valid_q [SETS];
  logic [TAG_BITS-1:0]       tag_q   [SETS][WAYS];
  logic [32*LINE_WORDS-1:0]  data_q  [SETS][WAYS];

  logic [IDX_BITS-1:0]       set_idx, miss_set, plru_idx;
  logic [TAG_BITS-1:0]       tag_in, miss_tag;
  logic [WSEL_W-1:0]         word_sel;
  logic                      hit_raw, hit_ok, fill_en, flush_now, vic_found;
  logic [1:0]                hit_way, plru_vic, vic_way, upd_way;
  logic [31:0]               hit_word;
  logic                      addr_unused;

  assign set_idx     = address[OFF_BITS +: IDX_BITS];
  assign tag_in      = address[31 -: TAG_BITS];
  assign word_sel    = WSEL_W'((address >> 2) & 32'(LINE_WORDS - 1));
  assign miss_set    = miss_line_q[IDX_BITS-1:0];
  assign miss_tag    = miss_line_q[LA_BITS-1 -: TAG_BITS];
  assign mem_address = miss_line_q;
  assign addr_unused = ^address[1:0];

`ifdef ICACHE_FLUSH_EN
  logic flush_pend_q, flush_pend_d;

  // A flush seen mid-miss is deferred until the refill lands back in IDLE.
  assign flush_now = (state_q == IDLE) && (flush || flush_pend_q);

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (state_q != IDLE && flush) flush_pend_d = 1'b1;
    else if (flush_now)           flush_pend_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) flush_pend_q <= 1'b0;
    else       flush_pend_q <= flush_pend_d;
  end
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    hit_raw  = 1'b0;
    hit_way  = 2'd0;
    hit_word = 32'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        hit_raw  = 1'b1;
        hit_way  = 2'(w);
        hit_word = data_q[set_idx][w][32*word_sel +: 32];
      end
    end
  end

  // Invalid ways are filled lowest-first before PLRU gets a say.
  always_comb begin
    vic_way   = plru_vic;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !valid_q[miss_set][w]) begin
        vic_way   = 2'(w);
        vic_found = 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    victim_d    = victim_q;
    busywait    = 1'b1;
    mem_read    = 1'b0;
    instruction = 32'd0;
    hit_ok      = 1'b0;
    fill_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_now) begin
          busywait = 1'b1;
        end else if (hit_raw) begin
          busywait    = 1'b0;
          instruction = hit_word;
          hit_ok      = 1'b1;
        end else begin
          miss_line_d = address[31:OFF_BITS];
          state_d     = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        if (!mem_busywait) begin
          victim_d = vic_way;
          state_d  = REFILL;
        end
      end
      REFILL: begin
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      busywait    = 1'b1;
      mem_read    = 1'b0;
      instruction = 32'd0;
      hit_ok      = 1'b0;
      fill_en     = 1'b0;
    end
  end

  assign plru_idx = (state_q == IDLE) ? set_idx : miss_set;
  assign upd_way  = fill_en ? victim_q : hit_way;

  icache_plru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_plru (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (flush_now),
    .index_i   (plru_idx),
    .upd_en_i  (hit_ok || fill_en),
    .upd_way_i (upd_way),
    .victim_o  (plru_vic)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      victim_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      victim_q    <= victim_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush_now) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (victim_q == 2'(w)) valid_q[miss_set][w] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data storage is not reset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (victim_q == 2'(w)) begin
          tag_q[miss_set][w]  <= miss_tag;
          data_q[miss_set][w] <= mem_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: default geometry (a) and 4-way/4-set/8-word (b);
// the flush checks are built in only when ICACHE_FLUSH_EN is defined.
module tb_icache_sa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst;
  logic [31:0]  addr [2];
  logic         mbw  [2];
  logic         flush;
  logic [127:0] rd_a;
  logic [255:0] rd_b;
  logic [31:0]  instr_a, instr_b;
  logic         bw_a, bw_b, mr_a, mr_b;
  logic [27:0]  ma_a;
  logic [26:0]  ma_b;

  icache_sa #(.SETS(8), .WAYS(2), .LINE_WORDS(4)) dut_a (
    .clock(clk), .reset(rst[0]), .address(addr[0]), .instruction(instr_a),
    .busywait(bw_a), .mem_read(mr_a), .mem_address(ma_a),
    .mem_readdata(rd_a), .mem_busywait(mbw[0])
`ifdef ICACHE_FLUSH_EN
    , .flush(flush)
`endif
  );

  icache_sa #(.SETS(4), .WAYS(4), .LINE_WORDS(8)) dut_b (
    .clock(clk), .reset(rst[1]), .address(addr[1]), .instruction(instr_b),
    .busywait(bw_b), .mem_read(mr_b), .mem_address(ma_b),
    .mem_readdata(rd_b), .mem_busywait(mbw[1])
`ifdef ICACHE_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  logic        busy_v [2];
  logic        mrd_v  [2];
  logic [31:0] ins_v  [2];
  logic [31:0] ma_v   [2];
  assign busy_v[0] = bw_a;    assign busy_v[1] = bw_b;
  assign mrd_v[0]  = mr_a;    assign mrd_v[1]  = mr_b;
  assign ins_v[0]  = instr_a; assign ins_v[1]  = instr_b;
  assign ma_v[0]   = 32'(ma_a);
  assign ma_v[1]   = 32'(ma_b);

  typedef struct {
    logic [31:0] instr;
    int          stall;
    logic [31:0] a;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt [2] = '{0, 0};
  int          mrd_cnt   [2] = '{0, 0};
  int          rd_cnt    [2] = '{0, 0};
  logic [31:0] last_ma   [2] = '{32'd0, 32'd0};
  int          lat = 3;
  int          base;

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
    return 32'hA500_0000 ^ (line << 8) ^ 32'(w);
  endfunction

  function automatic logic [31:0] expect_instr(input int i, input logic [31:0] a);
    int off, lw;
    off = (i == 0) ? 4 : 5;
    lw  = (i == 0) ? 4 : 8;
    return mem_word(a >> off, int'((a >> 2) & 32'(lw - 1)));
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory responder: data presented on the lat-th cycle of mem_read.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mrd_v[i]) begin
        rd_cnt[i] = rd_cnt[i] + 1;
        mbw[i]    = (rd_cnt[i] < lat);
      end else begin
        rd_cnt[i] = 0;
        mbw[i]    = 1'b1;
      end
    end
    for (int w = 0; w < 4; w++) rd_a[w*32 +: 32] = mem_word(ma_v[0], w);
    for (int w = 0; w < 8; w++) rd_b[w*32 +: 32] = mem_word(ma_v[1], w);
  end

  // Monitor: counts stall cycles and pops the scoreboard when a fetch completes.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mrd_v[i]) begin
        mrd_cnt[i] = mrd_cnt[i] + 1;
        last_ma[i] = ma_v[i];
      end
      if (!rst[i] && ((i == 0) ? q0.size() : q1.size()) > 0) begin
        if (busy_v[i]) begin
          stall_cnt[i] = stall_cnt[i] + 1;
        end else begin
          if (i == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          check(ins_v[i] == mon_e.instr, $sformatf("instr dut%0d @%h", i, mon_e.a),
                ins_v[i], mon_e.instr);
          check(stall_cnt[i] == mon_e.stall, $sformatf("stall dut%0d @%h", i, mon_e.a),
                32'(stall_cnt[i]), 32'(mon_e.stall));
          stall_cnt[i] = 0;
        end
      end
    end
  end

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic fetch(input int i, input logic [31:0] a, input int stall);
    exp_t e;
    int   n;
    e.instr = expect_instr(i, a);
    e.stall = stall;
    e.a     = a;
    addr[i] = a;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy_v[i]) break;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL fetch timeout dut%0d @%h", i, a);
      finish_run();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst   = 2'b11;
    addr[0] = 32'd0;
    addr[1] = 32'd0;
    flush = 1'b0;
    mbw[0] = 1'b1;
    mbw[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(bw_a == 1'b1, "reset busywait a", 32'(bw_a), 32'd1);
    check(mr_a == 1'b0, "reset mem_read a", 32'(mr_a), 32'd0);
    check(instr_a == 32'd0, "reset instruction a", instr_a, 32'd0);
    check(ma_a == 28'd0, "reset mem_address a", 32'(ma_a), 32'd0);
    check(bw_b == 1'b1, "reset busywait b", 32'(bw_b), 32'd1);
    check(mr_b == 1'b0, "reset mem_read b", 32'(mr_b), 32'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;

    // First miss and same-line hits
    fetch(0, 32'h40, 5);
    check(last_ma[0] == 32'h4, "miss mem_address 0x40", last_ma[0], 32'h4);
    check(mrd_cnt[0] == 3, "mem_read cycles 0x40", 32'(mrd_cnt[0]), 32'd3);
    fetch(0, 32'h44, 0);
    fetch(0, 32'h48, 0);
    fetch(0, 32'h4C, 0);
    check(mrd_cnt[0] == 3, "no mem_read on hits", 32'(mrd_cnt[0]), 32'd3);

    // Set 0 fills, PLRU eviction
    fetch(0, 32'h000, 5);
    fetch(0, 32'h080, 5);
    fetch(0, 32'h100, 5);
    fetch(0, 32'h084, 0);
    fetch(0, 32'h008, 5);
    fetch(0, 32'h088, 0);

    // Reset in the middle of a miss
    addr[0] = 32'h200;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mr_a) break;
    end
    check(mr_a == 1'b1, "mem_read before reset", 32'(mr_a), 32'd1);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(negedge clk);
    check(mr_a == 1'b0, "mem_read during reset", 32'(mr_a), 32'd0);
    check(bw_a == 1'b1, "busywait during reset", 32'(bw_a), 32'd1);
    addr[0] = 32'h080;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    fork
      fetch(0, 32'h080, 5);
      begin
        @(negedge clk);
        check(mr_a == 1'b0, "mem_read after reset", 32'(mr_a), 32'd0);
        check(ma_a == 28'd0, "mem_address after reset", 32'(ma_a), 32'd0);
      end
    join

`ifdef ICACHE_FLUSH_EN
    // Flush during a pending miss, then flush in IDLE
    base = mrd_cnt[0];
    fork
      fetch(0, 32'h300, 11);
      begin
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    check(mrd_cnt[0] - base == 6, "refetch after pending flush", 32'(mrd_cnt[0] - base), 32'd6);
    fetch(0, 32'h304, 0);
    fork
      fetch(0, 32'h308, 6);
      begin
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
`endif

    // 4-way / 4-set / 8-word geometry
    rst[1] = 1'b0;
    fetch(1, 32'h000, 5);
    fetch(1, 32'h080, 5);
    fetch(1, 32'h100, 5);
    fetch(1, 32'h01C, 0);
    fetch(1, 32'h180, 5);
    fetch(1, 32'h200, 5);
    fetch(1, 32'h004, 0);
    fetch(1, 32'h104, 0);
    fetch(1, 32'h184, 0);
    fetch(1, 32'h204, 0);
    fetch(1, 32'h080, 5);
    check(last_ma[1] == 32'h4, "miss mem_address b 0x080", last_ma[1], 32'h4);

    repeat (2) @(posedge clk);
    check(q0.size() == 0 && q1.size() == 0, "scoreboard drained",
          32'(q0.size() + q1.size()), 32'd0);
    finish_run();
  end

endmodule
